// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter that collapses per-bank request pulses
// into a registered valid/ready stream of bank addresses, one grant per transfer.
// Requests are held as sticky pending flags until granted.
module rr_grant_encoder #(
    parameter int n = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [n-1:0]         req,
    output logic [$clog2(n)-1:0] o_addr,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 busy
);
    localparam int a = $clog2(n);

    logic [n-1:0] r_pending;
    logic [a-1:0] r_ptr;
    logic [a-1:0] r_addr;
    logic         r_valid;

    logic [n-1:0] w_eff;
    logic [n-1:0] w_mask;
    logic [n-1:0] w_pick_vec;
    logic [n-1:0] w_onehot;
    logic [a-1:0] w_grant;
    logic [a-1:0] w_ptr_nxt;
    logic         w_any;
    logic         w_load;

    assign w_eff  = r_pending | req;
    assign w_any  = |w_eff;
    assign w_load = !r_valid || o_ready;

    // Rotating priority: prefer requests at or above ptr, otherwise fall back
    // to the lowest set bit overall (the wrapped part of the scan).
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < n; i++) begin
            w_mask[i] = (a'(i) >= r_ptr);
        end
        w_pick_vec = (|(w_eff & w_mask)) ? (w_eff & w_mask) : w_eff;
    end

    // Lowest-set-bit encoder over the chosen half, plus the matching one-hot.
    always_comb begin
        w_grant  = '0;
        w_onehot = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (w_pick_vec[i]) w_grant = a'(i);
        end
        for (int i = 0; i < n; i++) begin
            w_onehot[i] = w_any && (a'(i) == w_grant);
        end
        // Wrap modulo n, which differs from 2^a when n is not a power of two.
        w_ptr_nxt = (w_grant == a'(n - 1)) ? '0 : w_grant + 1'b1;
    end

    // Output register acts as a one-entry pipeline stage with bypassing ready;
    // new requests accumulate into pending while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_valid   <= 1'b0;
        end else if (w_load) begin
            if (w_any) begin
                r_addr    <= w_grant;
                r_valid   <= 1'b1;
                r_ptr     <= w_ptr_nxt;
                // A same-cycle pulse on the granted bank is consumed here.
                r_pending <= w_eff & ~w_onehot;
            end else begin
                r_valid   <= 1'b0;
                r_pending <= '0;
            end
        end else begin
            r_pending <= w_eff;
        end
    end

    assign o_addr  = r_addr;
    assign o_valid = r_valid;
    assign busy    = (|r_pending) || r_valid;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: a 32-bank and a 12-bank instance, directed
// vector table, hand sequences for reset/wrap corners, and a randomized run
// against a scan-based reference model.
module tb_rr_grant_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_ready;
    logic [31:0] req32;
    logic [11:0] req12;
    logic [4:0]  addr32;
    logic [3:0]  addr12;
    logic        valid32, valid12, busy32, busy12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_grant_encoder #(.n(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .req(req32), .o_addr(addr32),
        .o_valid(valid32), .o_ready(o_ready), .busy(busy32)
    );

    rr_grant_encoder #(.n(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .req(req12), .o_addr(addr12),
        .o_valid(valid12), .o_ready(o_ready), .busy(busy12)
    );

    // Reference model: index 0 is the 32-bank DUT, index 1 the 12-bank DUT.
    int        m_n[2] = '{32, 12};
    int        m_ptr[2];
    bit [31:0] m_pend[2];
    bit        m_valid[2];
    int        m_addr[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit rst, input bit [31:0] rq, input bit rdy);
        bit [31:0] eff;
        int        g;
        bit        found;
        if (!rst) begin
            m_ptr[d] = 0; m_pend[d] = '0; m_valid[d] = 0; m_addr[d] = 0;
            return;
        end
        eff = m_pend[d] | rq;
        if (!m_valid[d] || rdy) begin
            found = 0;
            g = 0;
            for (int k = 0; k < m_n[d]; k++) begin
                int idx;
                idx = (m_ptr[d] + k) % m_n[d];
                if (!found && eff[idx]) begin
                    g = idx;
                    found = 1;
                end
            end
            if (found) begin
                m_addr[d]  = g;
                m_valid[d] = 1;
                m_ptr[d]   = (g + 1) % m_n[d];
                eff[g]     = 1'b0;
                m_pend[d]  = eff;
            end else begin
                m_valid[d] = 0;
                m_pend[d]  = '0;
            end
        end else begin
            m_pend[d] = eff;
        end
    endtask

    task automatic cmp_model();
        check("m32_valid", int'(valid32), int'(m_valid[0]));
        check("m32_addr",  int'(addr32),  m_addr[0]);
        check("m32_busy",  int'(busy32),  int'(m_valid[0] || (m_pend[0] != 0)));
        check("m12_valid", int'(valid12), int'(m_valid[1]));
        check("m12_addr",  int'(addr12),  m_addr[1]);
        check("m12_busy",  int'(busy12),  int'(m_valid[1] || (m_pend[1] != 0)));
        check("m12_range", int'(addr12 < 4'd12), 1);
    endtask

    // Drive one cycle of inputs, advance past the edge, sample on negedge.
    task automatic step(input bit rst, input bit [31:0] r32, input bit [11:0] r12, input bit rdy);
        rst_n = rst; req32 = r32; req12 = r12; o_ready = rdy;
        model_step(0, rst, r32, rdy);
        model_step(1, rst, {20'd0, r12}, rdy);
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        bit        rst;
        bit [31:0] req;
        bit        rdy;
        bit        v;
        int        addr;
        bit        busy;
    } vec_t;

    function automatic vec_t mk(bit rst, bit [31:0] rq, bit rdy, bit v, int ad, bit b);
        vec_t t;
        t.rst = rst; t.req = rq; t.rdy = rdy; t.v = v; t.addr = ad; t.busy = b;
        return t;
    endfunction

    function automatic bit [31:0] bm(int i);
        bit [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    initial begin
        vec_t vt[$];
        rst_n = 1'b0; req32 = '0; req12 = '0; o_ready = 1'b1;

        // reset with all requests asserted, then release
        vt.push_back(mk(0, 32'hFFFF_FFFF, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'hFFFF_FFFF, 1, 0, 0, 0));
        vt.push_back(mk(1, 32'h0,         1, 0, 0, 0));
        // single request, ptr -> 6
        vt.push_back(mk(1, bm(5), 1, 1, 5, 1));
        vt.push_back(mk(1, 0,     1, 0, 5, 0));
        // round robin from reset, then wrap from ptr=31
        vt.push_back(mk(0, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, bm(3) | bm(7) | bm(30), 1, 1, 3, 1));
        vt.push_back(mk(1, 0, 1, 1, 7, 1));
        vt.push_back(mk(1, 0, 1, 1, 30, 1));
        vt.push_back(mk(1, 0, 1, 0, 30, 0));
        vt.push_back(mk(1, bm(3) | bm(7), 1, 1, 3, 1));
        vt.push_back(mk(1, 0, 1, 1, 7, 1));
        vt.push_back(mk(1, 0, 1, 0, 7, 0));
        // backpressure: grant 3 stalled 4 cycles while 1 and 7 arrive
        vt.push_back(mk(1, bm(3), 1, 1, 3, 1));
        vt.push_back(mk(1, bm(1), 0, 1, 3, 1));
        vt.push_back(mk(1, bm(7), 0, 1, 3, 1));
        vt.push_back(mk(1, 0,     0, 1, 3, 1));
        vt.push_back(mk(1, 0,     0, 1, 3, 1));
        vt.push_back(mk(1, 0,     1, 1, 7, 1));
        vt.push_back(mk(1, 0,     1, 1, 1, 1));
        vt.push_back(mk(1, 0,     1, 0, 1, 0));
        // held req[4] with a single contender pulse on 9
        vt.push_back(mk(1, bm(4),         1, 1, 4, 1));
        vt.push_back(mk(1, bm(4) | bm(9), 1, 1, 9, 1));
        vt.push_back(mk(1, bm(4),         1, 1, 4, 1));
        vt.push_back(mk(1, bm(4),         1, 1, 4, 1));
        vt.push_back(mk(1, bm(4),         1, 1, 4, 1));
        vt.push_back(mk(1, 0,             1, 0, 4, 0));
        vt.push_back(mk(1, 0,             1, 0, 4, 0));

        @(negedge clk);
        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].req, 12'd0, vt[i].rdy);
            check($sformatf("vec%0d_valid", i), int'(valid32), int'(vt[i].v));
            check($sformatf("vec%0d_addr", i),  int'(addr32),  vt[i].addr);
            check($sformatf("vec%0d_busy", i),  int'(busy32),  int'(vt[i].busy));
        end

        // reset mid-operation drops the stalled grant and pending requests
        step(1, bm(2) | bm(9), 12'd0, 0);
        check("mid_grant", int'(addr32), 9);
        step(1, bm(20), 12'd0, 0);
        check("mid_stall_busy", int'(busy32), 1);
        step(0, 32'hFFFF_FFFF, 12'd0, 0);
        check("mid_rst_valid", int'(valid32), 0);
        check("mid_rst_addr",  int'(addr32),  0);
        check("mid_rst_busy",  int'(busy32),  0);
        step(1, 0, 12'd0, 1);
        check("mid_post_valid", int'(valid32), 0);
        check("mid_post_busy",  int'(busy32),  0);
        step(1, bm(1) | bm(31), 12'd0, 1);
        check("mid_ptr0_addr", int'(addr32), 1);
        step(1, 0, 12'd0, 1);
        check("mid_ptr0_addr2", int'(addr32), 31);

        // n=12 wrap: 11 then ptr=0, then {0,11} -> 0, 11
        step(1, 0, 12'h800, 1);
        check("w12_a11", int'(addr12), 11);
        check("w12_v11", int'(valid12), 1);
        step(1, 0, 12'h000, 1);
        check("w12_idle", int'(valid12), 0);
        step(1, 0, 12'h801, 1);
        check("w12_a0", int'(addr12), 0);
        step(1, 0, 12'h000, 1);
        check("w12_b11", int'(addr12), 11);
        step(1, 0, 12'h000, 1);
        check("w12_end", int'(valid12), 0);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            bit [31:0] r32;
            bit [11:0] r12;
            bit        rst;
            r32 = '0;
            r12 = '0;
            for (int b = 0; b < 32; b++) if ($urandom_range(0, 15) == 0) r32[b] = 1'b1;
            for (int b = 0; b < 12; b++) if ($urandom_range(0, 9) == 0) r12[b] = 1'b1;
            if (c % 500 < 40) r32 = r32 | bm(c % 32);
            rst = ($urandom_range(0, 255) != 0);
            step(rst, r32, r12, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
